// File: rtl/pc_flag_unit_pkg.sv
// Shared definitions for the program-sequencing / flag unit: branch condition
// codes, control FSM states and bit positions inside the flag register.
package pc_flag_unit_pkg;

    typedef enum logic [2:0] {
        kBR_ALWAYS,
        kBR_Z,
        kBR_NZ,
        kBR_EQ,
        kBR_NE,
        kBR_EVEN,
        kBR_PAR,
        kBR_CARRY
    } branch_cond_t;

    typedef enum logic [1:0] {
        kIDLE,
        kRUN,
        kHALTED
    } seq_state_t;

    localparam int unsigned kF_ZERO     = 0;
    localparam int unsigned kF_BEVEN    = 1;
    localparam int unsigned kF_PARITY   = 2;
    localparam int unsigned kF_EQUAL    = 3;
    localparam int unsigned kF_CARRY    = 4;
    localparam int unsigned kFLAG_WIDTH = 5;

endpackage

// File: rtl/pc_flag_unit_if.sv
// Instruction/flag bus between the sequencer and its driver (decoder or bench).
interface pc_flag_unit_if #(
    parameter int unsigned PC_WIDTH = 10
);
    logic                START;
    logic                FLAG_WE;
    logic                ZERO_IN;
    logic                BEVEN_IN;
    logic                PARITY_IN;
    logic                EQUAL_IN;
    logic                CARRY_IN;
    logic                BRANCH_EN;
    logic [2:0]          BRANCH_COND;
    logic [PC_WIDTH-1:0] BRANCH_TARGET;
    logic                HALT_REQ;
    logic [PC_WIDTH-1:0] PC_OUT;
    logic [4:0]          FLAGS_OUT;
    logic                TAKEN;
    logic                BUSY;
    logic                DONE;

    modport master (
        output START, FLAG_WE, ZERO_IN, BEVEN_IN, PARITY_IN, EQUAL_IN, CARRY_IN,
               BRANCH_EN, BRANCH_COND, BRANCH_TARGET, HALT_REQ,
        input  PC_OUT, FLAGS_OUT, TAKEN, BUSY, DONE
    );

    modport slave (
        input  START, FLAG_WE, ZERO_IN, BEVEN_IN, PARITY_IN, EQUAL_IN, CARRY_IN,
               BRANCH_EN, BRANCH_COND, BRANCH_TARGET, HALT_REQ,
        output PC_OUT, FLAGS_OUT, TAKEN, BUSY, DONE
    );
endinterface

// File: rtl/pc_flag_unit_branch_cond_eval.sv
// Combinational branch-condition evaluator over the latched flag register.
module branch_cond_eval
    import pc_flag_unit_pkg::*;
(
    input  logic [kFLAG_WIDTH-1:0] flags,
    input  branch_cond_t           cond,
    output logic                   cond_true
);

    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            kBR_ALWAYS: cond_true = 1'b1;
            kBR_Z:      cond_true = flags[kF_ZERO];
            kBR_NZ:     cond_true = ~flags[kF_ZERO];
            kBR_EQ:     cond_true = flags[kF_EQUAL];
            kBR_NE:     cond_true = ~flags[kF_EQUAL];
            kBR_EVEN:   cond_true = flags[kF_BEVEN];
            kBR_PAR:    cond_true = flags[kF_PARITY];
            kBR_CARRY:  cond_true = flags[kF_CARRY];
        endcase
    end

endmodule

// File: rtl/pc_flag_unit.sv
// Program counter, IDLE/RUN/HALTED sequencer and ALU flag register; branches
// are resolved against the registered flags only.
module pc_flag_unit
    import pc_flag_unit_pkg::*;
#(
    parameter int unsigned         PC_WIDTH   = 10,
    parameter logic [PC_WIDTH-1:0] START_ADDR = '0
) (
    input  logic          CLK,
    input  logic          RESET_N,
    pc_flag_unit_if.slave bus
);

    seq_state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]       pc_q, pc_d;
    logic                      taken_q, taken_d;
    logic [kFLAG_WIDTH-1:0]    flags_q;
    logic                      cond_true;

    branch_cond_eval u_cond (
        .flags     (flags_q),
        .cond      (branch_cond_t'(bus.BRANCH_COND)),
        .cond_true (cond_true)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        unique case (state_q)
            kIDLE, kHALTED: begin
                if (bus.START) begin
                    state_d = kRUN;
                    pc_d    = START_ADDR;
                end
            end
            kRUN: begin
                // Halt outranks a branch in the same instruction slot.
                if (bus.HALT_REQ) begin
                    state_d = kHALTED;
                end else if (bus.BRANCH_EN && cond_true) begin
                    pc_d    = bus.BRANCH_TARGET;
                    taken_d = 1'b1;
                end else begin
                    pc_d    = pc_q + 1'b1;
                end
            end
            default: state_d = kIDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= kIDLE;
            pc_q    <= START_ADDR;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            flags_q <= '0;
        end else if (bus.FLAG_WE) begin
            flags_q[kF_ZERO]   <= bus.ZERO_IN;
            flags_q[kF_BEVEN]  <= bus.BEVEN_IN;
            flags_q[kF_PARITY] <= bus.PARITY_IN;
            flags_q[kF_EQUAL]  <= bus.EQUAL_IN;
            flags_q[kF_CARRY]  <= bus.CARRY_IN;
        end
    end

    assign bus.PC_OUT    = pc_q;
    assign bus.FLAGS_OUT = flags_q;
    assign bus.TAKEN     = taken_q;
    assign bus.BUSY      = (state_q == kRUN);
    assign bus.DONE      = (state_q == kHALTED);

endmodule

// File: doc/pc_flag_unit.md
Name: pc_flag_unit

Overview:
- Downstream consumer of the combinational ALU flags (ZERO, BEVEN, PARITY, EQUAL, carry out) and owner of program sequencing.
- Latches the flags into a 5-bit flag register and evaluates conditional branches against the latched flags.
- Holds the program counter and runs an IDLE/RUN/HALTED control FSM that issues START/DONE to the testbench.

Parameters:
- PC_WIDTH, 10, program counter and branch target width.
- START_ADDR, 0, PC value loaded on reset and on START.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- START  input  1  begin program at START_ADDR; honoured in IDLE and HALTED only.
- FLAG_WE  input  1  capture flag inputs at this edge.
- ZERO_IN, BEVEN_IN, PARITY_IN, EQUAL_IN, CARRY_IN  input  1 each  ALU flag outputs.
- BRANCH_EN  input  1  current instruction is a branch.
- BRANCH_COND  input  3  condition code (branch_cond_t).
- BRANCH_TARGET  input  PC_WIDTH  absolute target address.
- HALT_REQ  input  1  current instruction is halt.
- PC_OUT  output  PC_WIDTH  current instruction address.
- FLAGS_OUT  output  5  {CARRY, EQUAL, PARITY, BEVEN, ZERO}, registered.
- TAKEN  output  1  registered; high for one cycle after a taken branch.
- BUSY  output  1  high in RUN.
- DONE  output  1  high in HALTED.

Behaviour:
- Reset (async, RESET_N low): state=IDLE, PC_OUT=START_ADDR, FLAGS_OUT=0, TAKEN=0, BUSY=0, DONE=0. Reset asserted mid-program aborts immediately with no further PC update.
- IDLE: PC holds. START -> RUN with PC=START_ADDR.
- RUN, per rising edge, evaluated in this priority:
  - HALT_REQ: go to HALTED, PC holds, TAKEN=0. BRANCH_EN is ignored.
  - BRANCH_EN and condition true: PC=BRANCH_TARGET, TAKEN=1.
  - Otherwise: PC=PC+1 modulo 2^PC_WIDTH (all-ones wraps to 0), TAKEN=0.
  - START in RUN is ignored.
- HALTED: DONE=1, PC holds. START -> RUN with PC=START_ADDR, DONE drops at the same edge.
- Flag register: when FLAG_WE=1 the register loads all five inputs at the edge, in any state. It holds otherwise.
- Branch conditions always read the registered FLAGS_OUT, never the same-cycle inputs. If FLAG_WE and BRANCH_EN are both high in one cycle, the branch sees the old flags and the new flags are visible from the next cycle.
- Conditions (BRANCH_COND):
  - 0 ALWAYS: 1
  - 1 Z: ZERO
  - 2 NZ: !ZERO
  - 3 EQ: EQUAL
  - 4 NE: !EQUAL
  - 5 EVEN: BEVEN
  - 6 PAR: PARITY
  - 7 CARRY: CARRY
- BRANCH_EN, HALT_REQ and FLAG_WE outside RUN: no PC effect (FLAG_WE still loads flags).
- Latency: PC_OUT reflects a decision one cycle after the sampling edge. No combinational path from any input to any output.

Decomposition:
- Shared definitions package:
  - typedef enum logic [2:0] branch_cond_t {kBR_ALWAYS, kBR_Z, kBR_NZ, kBR_EQ, kBR_NE, kBR_EVEN, kBR_PAR, kBR_CARRY}
  - typedef enum logic [1:0] seq_state_t {kIDLE, kRUN, kHALTED}
  - localparam bit indices for FLAGS_OUT fields (kF_ZERO=0 .. kF_CARRY=4)
- Sub-module branch_cond_eval: combinational, inputs FLAGS_OUT and BRANCH_COND, output cond_true. It is verified standalone; everything else stays in pc_flag_unit.

Test Plan:
- Reset and start: RESET_N low with START_ADDR=0, release, START 1 cycle -> BUSY=1; PC_OUT reads 0,1,2,3 on successive edges; FLAGS_OUT=5'b00000.
- Flag-before-branch ordering: FLAG_WE with ZERO_IN=1, and in the same cycle BRANCH_EN, COND=Z, TARGET=0x40 -> not taken, PC+1. Next cycle repeat the branch -> PC=0x40, TAKEN=1 for exactly one cycle.
- All eight conditions: flags=5'b10101 (CARRY, PARITY, ZERO set), TARGET=0x15 -> taken for ALWAYS, Z, NE, PAR, CARRY; not taken for NZ, EQ, EVEN.
- Halt priority: HALT_REQ and BRANCH_EN (ALWAYS, TARGET=0x3FF) together at PC=7 -> HALTED, PC_OUT=7, DONE=1, TAKEN=0. Later START -> PC=0, DONE=0, BUSY=1.
- Wrap: branch to 0x3FF, then sequential step -> PC_OUT=0x000, still RUN.
- Async reset mid-run: pull RESET_N low between clock edges at PC=0x12 -> outputs immediately reach reset values (PC=START_ADDR, state IDLE). START while already in RUN -> ignored.
